out_capture_buffer: RTL and testbench

Downstream consumer of the CPU output port (outFlag / out). It captures every 25-bit word the CPU flags as valid into an on-chip FIFO and presents the words on a valid/ready drain interface to a slower sink (UART bridge, trace memory, bench monitor). It tracks captured and dropped counts, raises a sticky overflow flag, and can stop capturing after a programmed number of words.

---
 rtl/out_capture_buffer_if.sv | 29 ++
 rtl/out_capture_buffer.sv | 93 +++++++++
 tb/tb_out_capture_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_capture_buffer_if.sv
// Capture and drain signals between the CPU output port, the capture buffer and its sink.
// Drain handshake: a word transfers on a rising edge where drainValid and drainReady are both 1.
// drainValid never depends on drainReady, and drainData holds steady while drainValid=1 and drainReady=0.
// outFlag is a one-cycle strobe with no back-pressure; out is sampled when it is high.
interface out_capture_buffer_if #(
  parameter int DATAWIDTH = 25
);
  logic                 outFlag;
  logic [DATAWIDTH-1:0] out;
  logic                 drainValid;
  logic                 drainReady;
  logic [DATAWIDTH-1:0] drainData;

  modport master (
    output outFlag,
    output out,
    output drainReady,
    input  drainValid,
    input  drainData
  );

  modport slave (
    input  outFlag,
    input  out,
    input  drainReady,
    output drainValid,
    output drainData
  );
endinterface

// File: rtl/out_capture_buffer.sv
// Captures flagged CPU output words into a FIFO and drains them over a valid/ready port,
// with saturating captured/dropped counters, sticky overflow and an optional capture limit.
module out_capture_buffer #(
  parameter int DATAWIDTH  = 25,
  parameter int DEPTH      = 16,
  parameter int ADDRWIDTH  = 4,
  parameter int COUNTWIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  out_capture_buffer_if.slave   bus,
  input  logic [COUNTWIDTH-1:0] limit,
  input  logic                  clear,
  output logic [ADDRWIDTH:0]    level,
  output logic [COUNTWIDTH-1:0] captured,
  output logic [COUNTWIDTH-1:0] dropped,
  output logic                  overflow,
  output logic                  done
);

  localparam logic [ADDRWIDTH:0]    FULL_LEVEL = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [COUNTWIDTH-1:0] COUNT_MAX  = '1;

  logic [DATAWIDTH-1:0]  mem [DEPTH];
  logic [ADDRWIDTH-1:0]  rd_ptr;
  logic [ADDRWIDTH-1:0]  wr_ptr;
  logic                  full;
  logic                  pop;
  logic                  push_req;
  logic                  push_ok;
  logic                  drop;
  logic [COUNTWIDTH-1:0] captured_next;
  logic                  done_next;

  // Outputs come only from level, rd_ptr and memory, so no input reaches them combinationally.
  assign bus.drainValid = (level != '0);
  assign bus.drainData  = bus.drainValid ? mem[rd_ptr] : '0;

  assign full     = (level == FULL_LEVEL);
  assign pop      = bus.drainValid & bus.drainReady;
  assign push_req = bus.outFlag & ~done;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // done looks at the post-edge count so the word reaching the limit is the last one accepted.
  always_comb begin
    captured_next = captured;
    if (push_ok && (captured != COUNT_MAX)) begin
      captured_next = captured + 1'b1;
    end
    done_next = (limit != '0) && (captured_next >= limit);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      captured <= '0;
      dropped  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      captured <= captured_next;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != COUNT_MAX) begin
          dropped <= dropped + 1'b1;
        end
      end
      done <= done_next;
    end
  end

  // Storage is left uninitialised on reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push_ok) begin
      mem[wr_ptr] <= bus.out;
    end
  end

endmodule

// File: tb/tb_out_capture_buffer.sv
// Directed bench for out_capture_buffer: capture, overflow, full push/pop, limit, wrap and clear.
module tb_out_capture_buffer;

  localparam int DW = 25;
  localparam int CW = 16;

  logic          clock;
  logic          reset;
  logic          clear;
  logic [CW-1:0] limit;
  logic [4:0]    level;
  logic [CW-1:0] captured;
  logic [CW-1:0] dropped;
  logic          overflow;
  logic          done;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  out_capture_buffer_if #(.DATAWIDTH(DW)) bus ();

  out_capture_buffer #(
    .DATAWIDTH (DW),
    .DEPTH     (16),
    .ADDRWIDTH (4),
    .COUNTWIDTH(CW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .limit   (limit),
    .clear   (clear),
    .level   (level),
    .captured(captured),
    .dropped (dropped),
    .overflow(overflow),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: at the falling edge, any transfer about to happen is checked against the queue.
  task automatic cycle();
    logic [DW-1:0] head;
    @(negedge clock);
    if (bus.drainValid === 1'b1 && bus.drainReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.drainData), 32'hFFFF_FFFF);
      end else begin
        head = exp_q.pop_front();
        chk("drain_order", 32'(bus.drainData), 32'(head));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    bus.drainReady = 1'b0;
    bus.outFlag    = 1'b0;
    clear          = 1'b1;
    cycle();
    clear          = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    clear          = 1'b0;
    limit          = '0;
    bus.outFlag    = 1'b0;
    bus.out        = '0;
    bus.drainReady = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;

    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(bus.drainValid), 0);
    chk("rst_data", 32'(bus.drainData), 0);
    chk("rst_captured", 32'(captured), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_done", 32'(done), 0);

    // Streaming 1..15 with the sink always ready.
    bus.drainReady = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      bus.outFlag = 1'b1;
      bus.out     = DW'(i);
      exp_q.push_back(DW'(i));
      cycle();
      chk("t1_head", 32'(bus.drainData), 32'(i));
    end
    bus.outFlag = 1'b0;
    cycle();
    chk("t1_level", 32'(level), 0);
    chk("t1_captured", 32'(captured), 15);
    chk("t1_dropped", 32'(dropped), 0);
    chk("t1_overflow", 32'(overflow), 0);
    chk("t1_empty", 32'(exp_q.size()), 0);

    // Overfill with the sink stalled: 16 stored, 4 dropped.
    do_clear();
    for (int i = 0; i < 20; i++) begin
      bus.outFlag = 1'b1;
      bus.out     = DW'(100 + i);
      if (i < 16) exp_q.push_back(DW'(100 + i));
      cycle();
    end
    bus.outFlag = 1'b0;
    chk("t2_level", 32'(level), 16);
    chk("t2_captured", 32'(captured), 16);
    chk("t2_dropped", 32'(dropped), 4);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_hold", 32'(bus.drainData), 100);

    // Push and pop in the same cycle while full.
    bus.outFlag    = 1'b1;
    bus.out        = DW'(32'h1ABCDEF);
    bus.drainReady = 1'b1;
    exp_q.push_back(DW'(32'h1ABCDEF));
    cycle();
    bus.outFlag = 1'b0;
    chk("t3_level", 32'(level), 16);
    chk("t3_dropped", 32'(dropped), 4);
    chk("t3_captured", 32'(captured), 17);
    for (int i = 0; i < 16; i++) cycle();
    chk("t3_level_end", 32'(level), 0);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_empty", 32'(exp_q.size()), 0);

    // Capture limit of 5 on 8 back-to-back words, then unlimited again.
    do_clear();
    limit          = 16'd5;
    bus.drainReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.outFlag = 1'b1;
      bus.out     = DW'(i);
      if (i <= 5) exp_q.push_back(DW'(i));
      cycle();
      chk("t4_done", 32'(done), (i >= 5) ? 1 : 0);
    end
    bus.outFlag = 1'b0;
    cycle();
    chk("t4_captured", 32'(captured), 5);
    chk("t4_dropped", 32'(dropped), 0);
    chk("t4_empty", 32'(exp_q.size()), 0);
    limit = '0;
    cycle();
    chk("t4_done_off", 32'(done), 0);
    bus.outFlag = 1'b1;
    bus.out     = DW'(9);
    exp_q.push_back(DW'(9));
    cycle();
    bus.outFlag = 1'b0;
    chk("t4_resume", 32'(captured), 6);
    cycle();
    chk("t4_empty2", 32'(exp_q.size()), 0);

    // 40 words through the pointers (2.5 wraps) with the sink toggling.
    do_clear();
    for (int k = 0; k < 80; k++) begin
      bus.outFlag    = (k % 2 == 0);
      bus.drainReady = (k % 2 == 0);
      bus.out        = DW'(500 + k / 2);
      if (k % 2 == 0) exp_q.push_back(DW'(500 + k / 2));
      cycle();
      chk("t5_level_max", 32'(level <= 5'd16), 1);
    end
    bus.outFlag    = 1'b0;
    bus.drainReady = 1'b1;
    cycle();
    cycle();
    chk("t5_captured", 32'(captured), 40);
    chk("t5_dropped", 32'(dropped), 0);
    chk("t5_empty", 32'(exp_q.size()), 0);

    // Clear with level=7 and a word offered in the same cycle.
    do_clear();
    for (int i = 0; i < 7; i++) begin
      bus.outFlag = 1'b1;
      bus.out     = DW'(300 + i);
      cycle();
    end
    chk("t6_level_pre", 32'(level), 7);
    clear       = 1'b1;
    bus.outFlag = 1'b1;
    bus.out     = DW'(999);
    cycle();
    clear       = 1'b0;
    bus.outFlag = 1'b0;
    exp_q.delete();
    chk("t6_level", 32'(level), 0);
    chk("t6_valid", 32'(bus.drainValid), 0);
    chk("t6_captured", 32'(captured), 0);
    chk("t6_overflow", 32'(overflow), 0);
    chk("t6_data", 32'(bus.drainData), 0);
    bus.outFlag = 1'b1;
    bus.out     = DW'(32'h55);
    exp_q.push_back(DW'(32'h55));
    cycle();
    bus.outFlag = 1'b0;
    chk("t6_first", 32'(bus.drainData), 32'h55);
    chk("t6_level1", 32'(level), 1);
    bus.drainReady = 1'b1;
    cycle();
    chk("t6_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
